// File: rtl/pip_ctrl_n.sv
// pip_ctrl_n: parametrised pipeline stall/bubble/flush controller with perf counters and stall watchdog
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   stallreq             : per-requester stall levels, each mapped to a stage by REQ_STAGE_MAP
//   except_en, except_pc : redirect request and target from the mem stage
//   stall, bubble        : per-stage hold and NOP-insert vectors (combinational)
//   flush, new_pc        : flush pulse and redirect target (combinational)
//   flush_pending        : redirect accepted but held back by an external transaction
//   perf_sel, perf_clr   : counter select / clear
//   perf_data            : registered selected counter
//   wdog_trip            : sticky stall watchdog flag
module pip_ctrl_n #(
    parameter int NUM_STAGES = 6,
    parameter int NUM_REQ = 5,
    parameter int IDX_W = 3,
    parameter logic [NUM_REQ*IDX_W-1:0] REQ_STAGE_MAP = {3'd5, 3'd4, 3'd4, 3'd3, 3'd2},
    parameter logic [NUM_REQ-1:0] EXT_MASK = 5'b01100,
    parameter int CNT_W = 32,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    stallreq,
    input  logic                  except_en,
    input  logic [31:0]           except_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic                  flush_pending,
    input  logic [1:0]            perf_sel,
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      perf_data,
    output logic                  wdog_trip
);
    logic [NUM_STAGES-1:0] stall_raw;
    logic                  ext_busy;
    logic                  set_pend;
    logic [31:0]           pend_pc;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt, defer_cnt, run_len, longest, run_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + 1'b1 : c;
    endfunction

    // A request at stage s holds every stage from 0 up to s.
    always_comb begin
        stall_raw = '0;
        for (int r = 0; r < NUM_REQ; r++)
            for (int i = 0; i < NUM_STAGES; i++)
                if (stallreq[r] && REQ_STAGE_MAP[r*IDX_W +: IDX_W] >= IDX_W'(i))
                    stall_raw[i] = 1'b1;
    end

    assign ext_busy = |(stallreq & EXT_MASK);
    // A pending redirect has precedence over a new one; both wait for external traffic to drain.
    assign flush    = resetn & ~ext_busy & (flush_pending | except_en);
    assign new_pc   = flush ? (flush_pending ? pend_pc : except_pc) : '0;
    assign stall    = (resetn & ~flush) ? stall_raw : '0;
    assign bubble   = {stall[NUM_STAGES-2:0] & ~stall[NUM_STAGES-1:1], 1'b0};
    assign set_pend = except_en & ext_busy & ~flush_pending;
    assign run_nxt  = stall[0] ? sat_inc(run_len, 1'b1) : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            flush_pending <= 1'b0;
            pend_pc       <= '0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
            defer_cnt     <= '0;
            run_len       <= '0;
            longest       <= '0;
            wdog_trip     <= 1'b0;
            perf_data     <= '0;
        end else begin
            perf_data     <= perf_sel == 2'd0 ? stall_cnt :
                             perf_sel == 2'd1 ? flush_cnt :
                             perf_sel == 2'd2 ? defer_cnt : longest;
            flush_pending <= set_pend | (flush_pending & ext_busy);
            if (set_pend)
                pend_pc <= except_pc;
            if (perf_clr) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
                defer_cnt <= '0;
                run_len   <= '0;
                longest   <= '0;
                wdog_trip <= 1'b0;
            end else begin
                stall_cnt <= sat_inc(stall_cnt, stall[0]);
                flush_cnt <= sat_inc(flush_cnt, flush);
                defer_cnt <= sat_inc(defer_cnt, set_pend);
                run_len   <= run_nxt;
                longest   <= run_nxt > longest ? run_nxt : longest;
                wdog_trip <= wdog_trip | (64'(run_nxt) >= 64'(WDOG_LIMIT));
            end
        end
    end
endmodule

// File: tb/tb_pip_ctrl_n.sv
// tb_pip_ctrl_n: table, directed and random checks of pip_ctrl_n against a behavioural model
module tb_pip_ctrl_n;
    localparam int CMAX = 15;
    localparam int WLIM = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [4:0]  stallreq = '0;
    logic        except_en = 1'b0;
    logic [31:0] except_pc = '0;
    logic [5:0]  stall, bubble;
    logic        flush, flush_pending, wdog_trip;
    logic [31:0] new_pc;
    logic [1:0]  perf_sel = '0;
    logic        perf_clr = 1'b0;
    logic [3:0]  perf_data;

    int total = 0, bad = 0;
    bit armed = 0;

    int   m_pend = 0, m_sc = 0, m_fc = 0, m_dc = 0, m_run = 0, m_long = 0, m_wd = 0, m_pd = 0;
    logic [31:0] m_ppc = '0;
    int   stage_of[5] = '{2, 3, 4, 4, 5};

    pip_ctrl_n #(.CNT_W(4), .WDOG_LIMIT(WLIM)) dut (
        .clk(clk), .resetn(resetn), .stallreq(stallreq), .except_en(except_en),
        .except_pc(except_pc), .stall(stall), .bubble(bubble), .flush(flush),
        .new_pc(new_pc), .flush_pending(flush_pending), .perf_sel(perf_sel),
        .perf_clr(perf_clr), .perf_data(perf_data), .wdog_trip(wdog_trip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_stall(input logic [4:0] sr);
        int m = -1;
        for (int r = 0; r < 5; r++)
            if (sr[r] && stage_of[r] > m) m = stage_of[r];
        return m < 0 ? 6'd0 : 6'((1 << (m + 1)) - 1);
    endfunction

    function automatic int sat(input int x);
        return x >= CMAX ? CMAX : x + 1;
    endfunction

    // Checks current outputs against the model, then advances the model across one edge.
    task automatic tick();
        logic ext, fl, rise;
        logic [5:0] est;
        int sel;
        #1;
        ext  = |(stallreq & 5'b01100);
        fl   = resetn && !ext && (m_pend != 0 || except_en);
        est  = (resetn && !fl) ? exp_stall(stallreq) : 6'd0;
        chk("m_stall", {26'd0, stall}, {26'd0, est});
        chk("m_bubble", {26'd0, bubble}, {26'd0, (est << 1) & ~est});
        chk("m_flush", {31'd0, flush}, {31'd0, fl});
        if (fl) chk("m_new_pc", new_pc, m_pend != 0 ? m_ppc : except_pc);
        if (!resetn) chk("m_new_pc_rst", new_pc, 32'd0);
        if (armed) begin
            chk("m_pending", {31'd0, flush_pending}, 32'(m_pend));
            chk("m_perf_data", {28'd0, perf_data}, 32'(m_pd));
            chk("m_wdog", {31'd0, wdog_trip}, 32'(m_wd));
        end
        if (!resetn) begin
            m_pend = 0; m_ppc = '0; m_sc = 0; m_fc = 0; m_dc = 0;
            m_run = 0; m_long = 0; m_wd = 0; m_pd = 0;
        end else begin
            sel  = int'(perf_sel);
            m_pd = sel == 0 ? m_sc : sel == 1 ? m_fc : sel == 2 ? m_dc : m_long;
            rise = except_en && ext && m_pend == 0;
            if (perf_clr) begin
                m_sc = 0; m_fc = 0; m_dc = 0; m_run = 0; m_long = 0; m_wd = 0;
            end else begin
                if (est[0]) m_sc = sat(m_sc);
                if (fl) m_fc = sat(m_fc);
                if (rise) m_dc = sat(m_dc);
                m_run = est[0] ? sat(m_run) : 0;
                if (m_run > m_long) m_long = m_run;
                if (m_run >= WLIM) m_wd = 1;
            end
            if (rise) begin
                m_pend = 1;
                m_ppc = except_pc;
            end else if (m_pend != 0 && !ext) m_pend = 0;
        end
        @(posedge clk);
        armed = 1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        stallreq = '0; except_en = 0; perf_clr = 0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear();
        stallreq = '0; except_en = 0; perf_clr = 1;
        tick();
        perf_clr = 0;
    endtask

    typedef struct {
        logic [4:0]  sr;
        logic        en;
        logic [5:0]  e_stall;
        logic [5:0]  e_bub;
        logic        e_flush;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{5'b00010, 1'b0, 6'b001111, 6'b010000, 1'b0};
        vecs[1] = '{5'b10000, 1'b0, 6'b111111, 6'b000000, 1'b0};
        vecs[2] = '{5'b00001, 1'b0, 6'b000111, 6'b001000, 1'b0};
        vecs[3] = '{5'b01000, 1'b0, 6'b011111, 6'b100000, 1'b0};
        vecs[4] = '{5'b00000, 1'b0, 6'b000000, 6'b000000, 1'b0};
        vecs[5] = '{5'b00011, 1'b0, 6'b001111, 6'b010000, 1'b0};
        vecs[6] = '{5'b00001, 1'b1, 6'b000000, 6'b000000, 1'b1};
        vecs[7] = '{5'b00010, 1'b1, 6'b000000, 6'b000000, 1'b1};
        vecs[8] = '{5'b10001, 1'b1, 6'b000000, 6'b000000, 1'b1};

        // reset with every request and an exception asserted
        stallreq = 5'h1F; except_en = 1; except_pc = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        chk("rst_stall", {26'd0, stall}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        tick();
        tick();
        chk("rst_pending", {31'd0, flush_pending}, 32'd0);
        chk("rst_perf", {28'd0, perf_data}, 32'd0);
        chk("rst_wdog", {31'd0, wdog_trip}, 32'd0);
        resetn = 1;
        idle(2);

        foreach (vecs[k]) begin
            stallreq = vecs[k].sr; except_en = vecs[k].en; except_pc = 32'h1C00_0000 + 32'(k);
            #1;
            chk("vec_stall", {26'd0, stall}, {26'd0, vecs[k].e_stall});
            chk("vec_bubble", {26'd0, bubble}, {26'd0, vecs[k].e_bub});
            chk("vec_flush", {31'd0, flush}, {31'd0, vecs[k].e_flush});
            tick();
        end

        // immediate flush
        clear();
        stallreq = 5'b00001; except_en = 1; except_pc = 32'h1C00_8000;
        #1;
        chk("imm_flush", {31'd0, flush}, 32'd1);
        chk("imm_pc", new_pc, 32'h1C00_8000);
        chk("imm_stall", {26'd0, stall}, 32'd0);
        tick();
        perf_sel = 2'd1;
        idle(1);
        chk("imm_count", {28'd0, perf_data}, 32'd1);

        // deferred flush: oldest exception wins
        clear();
        stallreq = 5'b00100; except_en = 1; except_pc = 32'h1C00_0100;
        #1;
        chk("def_c1_flush", {31'd0, flush}, 32'd0);
        chk("def_c1_stall", {26'd0, stall}, 32'h1F);
        tick();
        except_pc = 32'h1C00_0200;
        chk("def_c2_pend", {31'd0, flush_pending}, 32'd1);
        tick();
        except_en = 0;
        chk("def_c3_pend", {31'd0, flush_pending}, 32'd1);
        tick();
        chk("def_c4_pend", {31'd0, flush_pending}, 32'd1);
        #1;
        chk("def_c4_flush", {31'd0, flush}, 32'd0);
        tick();
        stallreq = '0;
        #1;
        chk("def_c5_flush", {31'd0, flush}, 32'd1);
        chk("def_c5_pc", new_pc, 32'h1C00_0100);
        perf_sel = 2'd2;
        tick();
        chk("def_c6_pend", {31'd0, flush_pending}, 32'd0);
        #1;
        chk("def_c6_flush", {31'd0, flush}, 32'd0);
        idle(1);
        chk("def_count", {28'd0, perf_data}, 32'd1);

        // reset while pending drops the redirect
        stallreq = 5'b01000; except_en = 1; except_pc = 32'h1C00_0300;
        tick();
        except_en = 0;
        chk("rp_pend", {31'd0, flush_pending}, 32'd1);
        resetn = 0;
        tick();
        resetn = 1; stallreq = '0;
        #1;
        chk("rp_flush", {31'd0, flush}, 32'd0);
        chk("rp_pend0", {31'd0, flush_pending}, 32'd0);
        idle(1);

        // saturation and clear
        clear();
        stallreq = 5'b00001;
        for (int k = 0; k < 20; k++) tick();
        perf_sel = 2'd0;
        idle(1);
        chk("sat_stall_cnt", {28'd0, perf_data}, 32'd15);
        perf_sel = 2'd3;
        idle(1);
        chk("sat_longest", {28'd0, perf_data}, 32'd15);
        clear();
        for (int s = 0; s < 4; s++) begin
            perf_sel = 2'(s);
            idle(1);
            chk("clr_counter", {28'd0, perf_data}, 32'd0);
        end
        chk("clr_wdog", {31'd0, wdog_trip}, 32'd0);

        // watchdog boundary
        clear();
        stallreq = 5'b00010;
        for (int k = 0; k < WLIM - 1; k++) tick();
        idle(1);
        chk("wd_below", {31'd0, wdog_trip}, 32'd0);
        stallreq = 5'b00010;
        for (int k = 0; k < WLIM - 1; k++) tick();
        chk("wd_before", {31'd0, wdog_trip}, 32'd0);
        tick();
        chk("wd_trip", {31'd0, wdog_trip}, 32'd1);
        idle(3);
        chk("wd_sticky", {31'd0, wdog_trip}, 32'd1);
        clear();
        chk("wd_clr", {31'd0, wdog_trip}, 32'd0);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            resetn    = $urandom_range(0, 63) != 0;
            stallreq  = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            except_en = $urandom_range(0, 5) == 0;
            except_pc = $urandom;
            perf_sel  = 2'($urandom);
            perf_clr  = $urandom_range(0, 31) == 0;
            tick();
        end
        resetn = 1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pip_ctrl_n.md
Name: pip_ctrl_n

Overview:
Parametrised pipeline control unit for the LoongArch core; successor to the fixed 6-stage stall/flush controller. It generates per-stage stall and bubble vectors from NUM_REQ mapped stall requesters. Flushes are deferred while a non-abortable external transaction (cache/uncache/AXI) is in flight. It also provides stall/flush performance counters and a stall watchdog. It sits beside the pipeline stages in the core top, replacing the fixed controller.

Parameters:
NUM_STAGES, 6, pipeline stages controlled (bit 0 = PC/fetch request, bit NUM_STAGES-1 = writeback)
NUM_REQ, 5, number of stall request inputs
IDX_W, 3, width of one stage index; must satisfy 2**IDX_W >= NUM_STAGES
REQ_STAGE_MAP, {3'd5,3'd4,3'd4,3'd3,3'd2}, packed stage index per request (req0 in LSBs); default req0=ds, req1=es, req2=cache, req3=axi, req4=wb-side
EXT_MASK, 5'b01100, request bits that are external, non-abortable transactions
CNT_W, 32, perf counter width
WDOG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog

Ports:
clk  in  1  core clock
resetn  in  1  synchronous active-low reset
stallreq  in  NUM_REQ  stall requests, level, sampled every cycle
except_en  in  1  exception/ertn redirect request from mem stage
except_pc  in  32  redirect target accompanying except_en
stall  out  NUM_STAGES  stage hold vector
bubble  out  NUM_STAGES  bubble-insert vector (stage i loads NOP)
flush  out  1  pipeline flush pulse
new_pc  out  32  redirect target, valid while flush=1
flush_pending  out  1  flush accepted but deferred
perf_sel  in  2  0=stall cycles, 1=flush count, 2=deferred-flush count, 3=longest stall run
perf_clr  in  1  clear all counters and watchdog
perf_data  out  CNT_W  selected counter
wdog_trip  out  1  sticky watchdog flag

Behaviour:
- Reset (resetn=0 at posedge): stall=0, bubble=0, flush=0, new_pc=0, flush_pending=0, perf_data=0, wdog_trip=0; all counters and the pending target cleared.
- Stall vector, combinational: stall[i]=1 iff some active request r has REQ_STAGE_MAP[r] >= i. A request at stage s holds stages 0..s.
- bubble[i]=stall[i-1] & ~stall[i] for i>=1; bubble[0]=0.
- ext_busy = |(stallreq & EXT_MASK).
- Immediate flush: except_en=1, ext_busy=0, flush_pending=0 -> flush=1 and new_pc=except_pc in the same cycle (combinational). stall and bubble are forced 0 that cycle.
- Deferred flush: except_en=1 and ext_busy=1 -> at the edge, latch except_pc and set flush_pending=1. stall stays as computed, so the pipeline is frozen.
- While flush_pending=1:
  - further except_en is ignored (the oldest exception wins).
  - the first cycle with ext_busy=0: flush=1, new_pc=latched pc, stall/bubble forced 0.
  - flush_pending clears at the next edge.
- Reset mid-pending: pending is dropped and no flush is issued.
- Counters (CNT_W, saturating at all-ones, no wrap; each updates at the edge):
  - stall cycles: +1 each cycle stall[0]=1 and flush=0.
  - flush count: +1 per flush pulse.
  - deferred count: +1 each time flush_pending rises.
  - run length: counts consecutive stall[0] cycles, resets to 0 on a non-stalled cycle; longest run = running max of it.
- perf_data is registered: it shows the counter selected by perf_sel one cycle later.
- perf_clr=1: all counters, the run length and wdog_trip go to 0 at the edge. perf_clr takes priority over an increment in the same cycle.
- Watchdog: when run length reaches WDOG_LIMIT, wdog_trip=1 at that edge; it stays set until perf_clr or reset.
- Latency: stall/bubble/flush 0 cycles from inputs; flush_pending, counters, wdog_trip 1 cycle.

Test Plan:
- Reset: hold resetn=0 with stallreq=5'h1F and except_en=1 -> after edge all outputs 0, perf_data=0.
- Mapping: stallreq=5'b00010 (es, stage 3) -> stall=6'b001111, bubble=6'b010000. stallreq=5'b10000 -> stall=6'b111111, bubble=0.
- Immediate flush: except_en=1, except_pc=32'h1C00_8000, stallreq=5'b00001 -> same cycle flush=1, new_pc=32'h1C00_8000, stall=0; flush count reads 1.
- Deferred flush: stallreq=5'b00100 for 4 cycles, except_en=1 in cycle 1 (pc 32'h1C00_0100), except_en=1 in cycle 2 (pc 32'h1C00_0200):
  - flush_pending=1 from cycle 2 through 4.
  - flush=1 with new_pc=32'h1C00_0100 in cycle 5 only.
  - deferred count=1.
- Saturation/clear: with CNT_W=4, hold stallreq=1 for 20 cycles -> stall-cycle counter=15. Longest run reads 15. Then perf_clr -> all read 0.
- Watchdog: with WDOG_LIMIT=8, stall 7 cycles then release -> wdog_trip=0. Stall 8 cycles -> wdog_trip=1 and stays 1 after release until perf_clr.
